// File: rtl/arf_pkg.sv
// Shared types and port-priority helper for the architectural register file.
// Port matches are resolved highest-index-wins by last_hit().
package arf_pkg;

  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int NREAD  = 4;
  localparam int NWRITE = 2;
  localparam int NSET   = 2;

  // Upper bound on write ports that last_hit() can arbitrate.
  localparam int MAXP = 16;
  localparam int PIW  = 4;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

  typedef struct packed {
    logic           hit;
    logic [PIW-1:0] idx;
  } hit_t;

  function automatic hit_t last_hit(input logic [MAXP-1:0] match);
    hit_t r;
    r.hit = 1'b0;
    r.idx = '0;
    for (int p = 0; p < MAXP; p++) begin
      if (match[p]) begin
        r.hit = 1'b1;
        r.idx = PIW'(p);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/arf_busy_table.sv
// Busy scoreboard: flush beats set, set beats writeback clear, else hold.
// Also exports the next-state vector so reads can see same-cycle updates.
module arf_busy_table #(
  parameter int NWRITE = arf_pkg::NWRITE,
  parameter int NSET   = arf_pkg::NSET,
  parameter int AW     = arf_pkg::AW
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_flush,
  input  logic [NWRITE-1:0]    i_wen,
  input  logic [NWRITE*AW-1:0] i_waddr,
  input  logic [NSET-1:0]      i_sen,
  input  logic [NSET*AW-1:0]   i_saddr,
  output logic [2**AW-1:0]     o_busy_vec,
  output logic [2**AW-1:0]     o_busy_nxt
);

  localparam int NREG = 2**AW;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_nxt;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int j = 0; j < NWRITE; j++) begin
      if (i_wen[j]) w_clr[i_waddr[j*AW +: AW]] = 1'b1;
    end
    for (int s = 0; s < NSET; s++) begin
      if (i_sen[s]) w_set[i_saddr[s*AW +: AW]] = 1'b1;
    end
    // Register 0 is hardwired: never becomes busy.
    w_set[0] = 1'b0;
    w_clr[0] = 1'b0;
    w_nxt = i_flush ? '0 : (w_set | (r_busy & ~w_clr));
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_busy <= '0;
    else         r_busy <= w_nxt;
  end

  assign o_busy_vec = r_busy;
  assign o_busy_nxt = w_nxt;

endmodule

// File: rtl/arf_sb.sv
// Parametrised architectural register file with integrated busy scoreboard
// and optional same-cycle write-to-read bypass.
module arf_sb #(
  parameter int NREAD  = arf_pkg::NREAD,
  parameter int NWRITE = arf_pkg::NWRITE,
  parameter int NSET   = arf_pkg::NSET,
  parameter int AW     = arf_pkg::AW,
  parameter int DW     = arf_pkg::DW,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREAD*AW-1:0]  raddr,
  output logic [NREAD*DW-1:0]  rdata,
  output logic [NREAD-1:0]     rbusy,
  input  logic [NWRITE-1:0]    wen,
  input  logic [NWRITE*AW-1:0] waddr,
  input  logic [NWRITE*DW-1:0] wdata,
  input  logic [NSET-1:0]      sen,
  input  logic [NSET*AW-1:0]   saddr,
  input  logic                 flush,
  output logic [2**AW-1:0]     busy_vec
);

  import arf_pkg::*;

  localparam int NREG = 2**AW;

  logic [DW-1:0]   r_mem [NREG];
  logic            w_whit [NREG];
  logic [PIW-1:0]  w_widx [NREG];
  logic [NREG-1:0] w_busy_nxt;

  arf_busy_table #(
    .NWRITE (NWRITE),
    .NSET   (NSET),
    .AW     (AW)
  ) u_busy (
    .clk        (clk),
    .resetn     (resetn),
    .i_flush    (flush),
    .i_wen      (wen),
    .i_waddr    (waddr),
    .i_sen      (sen),
    .i_saddr    (saddr),
    .o_busy_vec (busy_vec),
    .o_busy_nxt (w_busy_nxt)
  );

  // Per-register write select; register 0 is never a candidate.
  always_comb begin
    logic [MAXP-1:0] m;
    hit_t            h;
    m = '0;
    h = '0;
    for (int i = 0; i < NREG; i++) begin
      w_whit[i] = 1'b0;
      w_widx[i] = '0;
    end
    for (int i = 1; i < NREG; i++) begin
      m = '0;
      for (int j = 0; j < NWRITE; j++) begin
        m[j] = wen[j] && (waddr[j*AW +: AW] == AW'(i));
      end
      h = last_hit(m);
      w_whit[i] = h.hit;
      w_widx[i] = h.idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_whit[i]) r_mem[i] <= wdata[int'(w_widx[i])*DW +: DW];
      end
    end
  end

  always_comb begin
    logic [AW-1:0]   a;
    logic [MAXP-1:0] m;
    hit_t            h;
    a = '0;
    m = '0;
    h = '0;
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NREAD; k++) begin
      a = raddr[k*AW +: AW];
      m = '0;
      for (int j = 0; j < NWRITE; j++) begin
        m[j] = wen[j] && (waddr[j*AW +: AW] == a);
      end
      h = last_hit(m);
      if ((BYPASS != 0) && (a != '0) && h.hit)
        rdata[k*DW +: DW] = wdata[int'(h.idx)*DW +: DW];
      else
        rdata[k*DW +: DW] = r_mem[a];
      rbusy[k] = (BYPASS != 0) ? w_busy_nxt[a] : busy_vec[a];
    end
  end

endmodule

// File: tb/tb_arf_sb.sv
// Bench for arf_sb: directed scenarios plus randomized traffic compared against
// a behavioural register/scoreboard model. Runs BYPASS=1 and BYPASS=0 side by side.
module tb_arf_sb;

  localparam int NREAD = 4, NWRITE = 2, NSET = 2, AW = 5, DW = 32, NREG = 32;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic [NREAD*AW-1:0]  raddr = '0;
  logic [NWRITE-1:0]    wen = '0;
  logic [NWRITE*AW-1:0] waddr = '0;
  logic [NWRITE*DW-1:0] wdata = '0;
  logic [NSET-1:0]      sen = '0;
  logic [NSET*AW-1:0]   saddr = '0;
  logic                 flush = 1'b0;

  logic [NREAD*DW-1:0] rdata_b, rdata_n;
  logic [NREAD-1:0]    rbusy_b, rbusy_n;
  logic [NREG-1:0]     bv_b, bv_n;

  int ncmp = 0;
  int nfail = 0;

  logic [DW-1:0]   m_mem [NREG];
  logic [NREG-1:0] m_busy;

  always #5 clk = ~clk;

  arf_sb #(.NREAD(NREAD), .NWRITE(NWRITE), .NSET(NSET), .AW(AW), .DW(DW), .BYPASS(1)) u_b (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .wen(wen), .waddr(waddr), .wdata(wdata), .sen(sen), .saddr(saddr),
    .flush(flush), .busy_vec(bv_b));

  arf_sb #(.NREAD(NREAD), .NWRITE(NWRITE), .NSET(NSET), .AW(AW), .DW(DW), .BYPASS(0)) u_n (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .wen(wen), .waddr(waddr), .wdata(wdata), .sen(sen), .saddr(saddr),
    .flush(flush), .busy_vec(bv_n));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = '0; sen = '0; flush = 1'b0;
  endtask

  task automatic wr(input int j, input int a, input logic [DW-1:0] d);
    wen[j] = 1'b1;
    waddr[j*AW +: AW] = AW'(a);
    wdata[j*DW +: DW] = d;
  endtask

  task automatic st(input int s, input int a);
    sen[s] = 1'b1;
    saddr[s*AW +: AW] = AW'(a);
  endtask

  task automatic rd(input int k, input int a);
    raddr[k*AW +: AW] = AW'(a);
  endtask

  // Reference model: register file as an array, scoreboard as a bit set.
  function automatic logic [DW-1:0] exp_rdata(input int k, input bit byp);
    int a;
    logic [DW-1:0] v;
    a = int'(raddr[k*AW +: AW]);
    if (a == 0) return '0;
    v = m_mem[a];
    if (byp)
      for (int j = 0; j < NWRITE; j++)
        if (wen[j] && int'(waddr[j*AW +: AW]) == a) v = wdata[j*DW +: DW];
    return v;
  endfunction

  function automatic logic exp_rbusy(input int k, input bit byp);
    int a;
    a = int'(raddr[k*AW +: AW]);
    if (a == 0) return 1'b0;
    if (!byp) return m_busy[a];
    if (flush) return 1'b0;
    for (int s = 0; s < NSET; s++)
      if (sen[s] && int'(saddr[s*AW +: AW]) == a) return 1'b1;
    for (int j = 0; j < NWRITE; j++)
      if (wen[j] && int'(waddr[j*AW +: AW]) == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_step();
    logic [NREG-1:0] nb;
    int a;
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) m_mem[i] = '0;
      m_busy = '0;
      return;
    end
    nb = m_busy;
    for (int j = 0; j < NWRITE; j++) begin
      a = int'(waddr[j*AW +: AW]);
      if (wen[j] && a != 0) begin
        m_mem[a] = wdata[j*DW +: DW];
        nb[a] = 1'b0;
      end
    end
    for (int s = 0; s < NSET; s++) begin
      a = int'(saddr[s*AW +: AW]);
      if (sen[s] && a != 0) nb[a] = 1'b1;
    end
    if (flush) nb = '0;
    m_busy = nb;
  endtask

  task automatic test_reset();
    resetn = 1'b0; idle();
    tick(); tick();
    resetn = 1'b1;
    rd(0, 0); rd(1, 1); rd(2, 17); rd(3, 31);
    #1;
    for (int k = 0; k < NREAD; k++) begin
      ncmp++; if (rdata_b[k*DW +: DW] !== '0) begin nfail++; $display("FAIL reset_rdata_b port %0d: got %h want 0", k, rdata_b[k*DW +: DW]); end
      ncmp++; if (rdata_n[k*DW +: DW] !== '0) begin nfail++; $display("FAIL reset_rdata_n port %0d: got %h want 0", k, rdata_n[k*DW +: DW]); end
    end
    ncmp++; if (rbusy_b !== '0 || rbusy_n !== '0) begin nfail++; $display("FAIL reset_rbusy: got %b/%b want 0", rbusy_b, rbusy_n); end
    ncmp++; if (bv_b !== '0 || bv_n !== '0) begin nfail++; $display("FAIL reset_busy_vec: got %h/%h want 0", bv_b, bv_n); end
  endtask

  task automatic test_write_priority();
    idle();
    wr(0, 5, 32'hAAAA0000); wr(1, 5, 32'h5555FFFF);
    tick(); idle();
    rd(0, 5); #1;
    ncmp++; if (rdata_b[0 +: DW] !== 32'h5555FFFF) begin nfail++; $display("FAIL wprio_b: got %h want 5555ffff", rdata_b[0 +: DW]); end
    ncmp++; if (rdata_n[0 +: DW] !== 32'h5555FFFF) begin nfail++; $display("FAIL wprio_n: got %h want 5555ffff", rdata_n[0 +: DW]); end
    wr(0, 0, 32'hDEADBEEF); rd(0, 0); #1;
    ncmp++; if (rdata_b[0 +: DW] !== '0) begin nfail++; $display("FAIL r0_bypass: got %h want 0", rdata_b[0 +: DW]); end
    tick(); idle(); #1;
    ncmp++; if (rdata_b[0 +: DW] !== '0 || rdata_n[0 +: DW] !== '0) begin nfail++; $display("FAIL r0_write: got %h/%h want 0", rdata_b[0 +: DW], rdata_n[0 +: DW]); end
  endtask

  task automatic test_bypass();
    idle(); st(0, 9);
    tick(); idle();
    wr(0, 9, 32'h12345678); rd(1, 9); #1;
    ncmp++; if (rdata_b[DW +: DW] !== 32'h12345678) begin nfail++; $display("FAIL byp_rdata: got %h want 12345678", rdata_b[DW +: DW]); end
    ncmp++; if (rbusy_b[1] !== 1'b0) begin nfail++; $display("FAIL byp_rbusy: got %b want 0", rbusy_b[1]); end
    ncmp++; if (rdata_n[DW +: DW] !== '0) begin nfail++; $display("FAIL nobyp_rdata: got %h want 0", rdata_n[DW +: DW]); end
    ncmp++; if (rbusy_n[1] !== 1'b1) begin nfail++; $display("FAIL nobyp_rbusy: got %b want 1", rbusy_n[1]); end
    tick(); idle(); #1;
    ncmp++; if (rdata_n[DW +: DW] !== 32'h12345678) begin nfail++; $display("FAIL nobyp_later: got %h want 12345678", rdata_n[DW +: DW]); end
    ncmp++; if (rbusy_n[1] !== 1'b0 || bv_n[9] !== 1'b0) begin nfail++; $display("FAIL byp_clear: got %b/%b want 0", rbusy_n[1], bv_n[9]); end
  endtask

  task automatic test_scoreboard();
    idle(); st(0, 3); rd(0, 3); #1;
    ncmp++; if (rbusy_b[0] !== 1'b1 || rbusy_n[0] !== 1'b0) begin nfail++; $display("FAIL sb_set_view: got %b/%b want 1/0", rbusy_b[0], rbusy_n[0]); end
    tick(); idle(); #1;
    ncmp++; if (bv_b[3] !== 1'b1 || bv_n[3] !== 1'b1) begin nfail++; $display("FAIL sb_set: got %b/%b want 1", bv_b[3], bv_n[3]); end
    wr(0, 3, 32'h77);
    tick(); idle(); #1;
    ncmp++; if (bv_b[3] !== 1'b0 || bv_n[3] !== 1'b0) begin nfail++; $display("FAIL sb_clear: got %b/%b want 0", bv_b[3], bv_n[3]); end
    ncmp++; if (rdata_n[0 +: DW] !== 32'h77) begin nfail++; $display("FAIL sb_data: got %h want 77", rdata_n[0 +: DW]); end
  endtask

  task automatic test_set_clear_flush();
    idle(); st(0, 4);
    tick(); idle();
    wr(0, 4, 32'h44); st(1, 4); rd(2, 4); #1;
    ncmp++; if (rbusy_b[2] !== 1'b1) begin nfail++; $display("FAIL setclr_rbusy: got %b want 1", rbusy_b[2]); end
    tick(); idle(); #1;
    ncmp++; if (bv_b[4] !== 1'b1 || bv_n[4] !== 1'b1) begin nfail++; $display("FAIL setclr_busy: got %b/%b want 1", bv_b[4], bv_n[4]); end
    flush = 1'b1; st(0, 6); wr(1, 7, 32'h1); rd(3, 6); #1;
    ncmp++; if (rbusy_b[2] !== 1'b0 || rbusy_b[3] !== 1'b0) begin nfail++; $display("FAIL flush_rbusy: got %b want 0", rbusy_b); end
    tick(); idle(); rd(0, 7); #1;
    ncmp++; if (bv_b !== '0 || bv_n !== '0) begin nfail++; $display("FAIL flush_busy: got %h/%h want 0", bv_b, bv_n); end
    ncmp++; if (rdata_n[0 +: DW] !== 32'h1) begin nfail++; $display("FAIL flush_write: got %h want 1", rdata_n[0 +: DW]); end
    st(0, 0);
    tick(); idle(); #1;
    ncmp++; if (bv_b[0] !== 1'b0 || bv_n[0] !== 1'b0) begin nfail++; $display("FAIL r0_set: got %b/%b want 0", bv_b[0], bv_n[0]); end
  endtask

  task automatic test_reset_mid();
    idle(); st(0, 3); st(1, 8); wr(0, 8, 32'hFF);
    tick(); idle(); rd(0, 8); #1;
    ncmp++; if (bv_n[3] !== 1'b1 || bv_n[8] !== 1'b1 || rdata_n[0 +: DW] !== 32'hFF) begin nfail++; $display("FAIL mid_setup: got %b%b %h want 11 ff", bv_n[3], bv_n[8], rdata_n[0 +: DW]); end
    resetn = 1'b0; wr(1, 8, 32'h123); st(0, 10);
    tick(); resetn = 1'b1; idle();
    rd(0, 8); rd(1, 3); rd(2, 10); rd(3, 5); #1;
    ncmp++; if (bv_b !== '0 || bv_n !== '0) begin nfail++; $display("FAIL mid_busy: got %h/%h want 0", bv_b, bv_n); end
    ncmp++; if (rdata_b !== '0 || rdata_n !== '0) begin nfail++; $display("FAIL mid_rdata: got %h/%h want 0", rdata_b, rdata_n); end
  endtask

  function automatic int rand_addr();
    return $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NREG-1));
  endfunction

  task automatic test_random();
    resetn = 1'b0; idle(); model_step();
    tick(); resetn = 1'b1;
    for (int c = 0; c < 400; c++) begin
      resetn = ($urandom_range(0, 149) != 0);
      flush  = ($urandom_range(0, 19) == 0);
      for (int j = 0; j < NWRITE; j++) begin
        wen[j] = $urandom_range(0, 1);
        waddr[j*AW +: AW] = AW'(rand_addr());
        wdata[j*DW +: DW] = $urandom;
      end
      for (int s = 0; s < NSET; s++) begin
        sen[s] = $urandom_range(0, 1);
        saddr[s*AW +: AW] = AW'(rand_addr());
      end
      for (int k = 0; k < NREAD; k++) raddr[k*AW +: AW] = AW'(rand_addr());
      #2;
      for (int k = 0; k < NREAD; k++) begin
        ncmp++; if (rdata_b[k*DW +: DW] !== exp_rdata(k, 1)) begin nfail++; $display("FAIL rnd_rdata_b cyc %0d port %0d: got %h want %h", c, k, rdata_b[k*DW +: DW], exp_rdata(k, 1)); end
        ncmp++; if (rdata_n[k*DW +: DW] !== exp_rdata(k, 0)) begin nfail++; $display("FAIL rnd_rdata_n cyc %0d port %0d: got %h want %h", c, k, rdata_n[k*DW +: DW], exp_rdata(k, 0)); end
        ncmp++; if (rbusy_b[k] !== exp_rbusy(k, 1)) begin nfail++; $display("FAIL rnd_rbusy_b cyc %0d port %0d: got %b want %b", c, k, rbusy_b[k], exp_rbusy(k, 1)); end
        ncmp++; if (rbusy_n[k] !== exp_rbusy(k, 0)) begin nfail++; $display("FAIL rnd_rbusy_n cyc %0d port %0d: got %b want %b", c, k, rbusy_n[k], exp_rbusy(k, 0)); end
      end
      model_step();
      tick();
      ncmp++; if (bv_b !== m_busy) begin nfail++; $display("FAIL rnd_busy_b cyc %0d: got %h want %h", c, bv_b, m_busy); end
      ncmp++; if (bv_n !== m_busy) begin nfail++; $display("FAIL rnd_busy_n cyc %0d: got %h want %h", c, bv_n, m_busy); end
    end
    resetn = 1'b1; idle();
  endtask

  initial begin
    test_reset();
    test_write_priority();
    test_bypass();
    test_scoreboard();
    test_set_clear_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/arf_sb.md
Name: arf_sb

Overview:
- Parametrised architectural register file with an integrated busy scoreboard. Next generation of the fixed 4R/2W ARF.
- Read, write, dispatch-set and writeback-clear port counts are generic. Same-cycle write-to-read bypass is optional.
- Sits between decode/dispatch (read operands, mark destinations busy) and writeback/commit (write results, clear busy).
- Issue logic stalls on rbusy.

Parameters:
- NREAD, 4, number of read ports
- NWRITE, 2, number of write ports; higher index has priority on address collision
- NSET, 2, number of dispatch busy-set ports
- AW, 5, register address width; depth = 2**AW
- DW, 32, data width
- BYPASS, 1, 1 = same-cycle write data/clear visible on read ports; 0 = registered view only

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- raddr  in  NREAD*AW  read addresses, port k at bits [k*AW +: AW]
- rdata  out  NREAD*DW  read data, combinational
- rbusy  out  NREAD  busy bit of each read address, combinational
- wen  in  NWRITE  write enables
- waddr  in  NWRITE*AW  write addresses
- wdata  in  NWRITE*DW  write data
- sen  in  NSET  busy-set enables (dispatch)
- saddr  in  NSET*AW  destination registers to mark busy
- flush  in  1  clear all busy bits (pipeline squash)
- busy_vec  out  2**AW  registered busy bits, bit i = register i

Behaviour:
- Reset: resetn, synchronous, active-low; clock clk. On a clk edge with resetn=0, all registers are set to 0 and all busy bits to 0. Reset overrides every other same-cycle input.
- Register 0: always reads 0, never written, never busy. Writes and sets to address 0 are dropped.
- Write arbitration: reg i is written when any port has wen[j] && waddr[j]==i. Data comes from the highest-index matching port. Non-matching registers hold their value.
- Write latency: the value is stored at the next clk edge.
- Read, BYPASS=0: rdata[k] = stored value. rbusy[k] = busy_vec[raddr[k]].
- Read, BYPASS=1: if any wen[j] hits raddr[k] (nonzero), rdata[k] = winning wdata, as if already written, and rbusy[k] = 0, unless a same-cycle set targets the same register. Otherwise the stored view applies.
- Busy clear: every accepted write clears the busy bit of its address. Writeback implies completion.
- Busy update per register i, in priority order:
  - flush=1: busy[i] <= 0. All same-cycle sets are dropped; writes still land.
  - else set hit i: busy[i] <= 1. A set beats a same-cycle clear, because a new producer has been dispatched.
  - else write hit i: busy[i] <= 0.
  - else hold.
- rbusy with BYPASS=1 applies the same priority combinationally, with flush forcing 0.
- Duplicate sets or duplicate writes to one register in the same cycle are legal. Sets are idempotent; writes are resolved by port priority.
- Port counts are independent. NREAD, NWRITE, NSET >= 1. No structural hazards or stalls inside the block.
- No combinational path from rdata to any input other than through the bypass mux.

Decomposition:
- Package arf_pkg:
  - default localparams: AW=5, DW=32, NREAD=4, NWRITE=2, NSET=2
  - typedef reg_addr_t (logic [AW-1:0])
  - typedef reg_data_t (logic [DW-1:0])
  - function last_hit(), returning the highest-index matching port and a hit flag; shared by the write and bypass logic
- Sub-module arf_busy_table:
  - owns busy_vec and the set/clear/flush priority
  - exports a combinational next-busy lookup for rbusy
- Storage array and bypass mux stay in arf_sb.

Test Plan:
- Reset + read: hold resetn=0 two cycles, release; raddr0..3 = 0,1,17,31 -> rdata all 0, rbusy all 0, busy_vec = 0.
- Write priority: wen=2'b11, waddr0=waddr1=5, wdata0=0xAAAA0000, wdata1=0x5555FFFF -> next cycle raddr0=5 reads 0x5555FFFF. Write to r0 with 0xDEADBEEF -> r0 still reads 0.
- Bypass: BYPASS=1, wen0=1, waddr0=9, wdata0=0x12345678, raddr1=9 same cycle -> rdata1=0x12345678, rbusy1=0. With BYPASS=0 -> rdata1 = old value 0 until the next cycle.
- Scoreboard lifecycle: sen0=1, saddr0=3 -> busy_vec[3]=1 next cycle. Write r3=0x77 -> busy_vec[3]=0 next cycle, r3 reads 0x77.
- Simultaneous set/clear and flush: busy[4]=1; write r4 and set r4 in the same cycle -> busy[4]=1. Then flush=1 with sen0 on saddr=6 and a write r7=0x1 -> busy_vec=0, r7=0x1. Set to r0 -> busy_vec[0] stays 0.
- Reset mid-operation: busy[3]=busy[8]=1, r8=0xFF; assert resetn=0 while wen1 targets r8 and sen0 targets r10 -> next cycle all registers 0, busy_vec=0.
